wall_kick_sequencer: RTL and testbench
======================================

WALL_KICK_SEQUENCER -- requirements
Module: wall_kick_sequencer

Interface
REQ-001 SHALL have parameter MAX_TESTS, default 5, number of kick table entries tried per 90-degree rotation (legal 1..5).
REQ-002 SHALL have parameter ENABLE_180, default 0, which enables 180-degree rotation when 1.
REQ-003 SHALL have parameter OFFSET_W, default 4, the signed width of all dx/dy outputs.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_l  input  1  asynchronous, active-low reset.
REQ-006 rot_req  input  1  rotation request; sampled only in IDLE.
REQ-007 rot_dir  input  2  01 = CW, 10 = CCW, 11 = 180, 00 = none.
REQ-008 is_i_piece  input  1  selects the I-tetromino kick tables.
REQ-009 cur_orient  input  orientation_t  current orientation; sampled with rot_req.
REQ-010 cancel  input  1  synchronous abort.
REQ-011 test_valid  output  1  candidate placement presented to the collision checker.
REQ-012 test_dx, test_dy  output  OFFSET_W each  signed candidate offset.
REQ-013 test_orient  output  orientation_t  target orientation of the candidate.
REQ-014 test_ack  input  1  checker has evaluated the candidate.
REQ-015 test_fits  input  1  candidate is collision-free; valid only when test_ack is high.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 done_ok  output  1  rotation succeeded; valid when done is high.
REQ-019 new_orient, kick_dx, kick_dy, kick_idx  output  orientation_t / OFFSET_W / OFFSET_W / 3  accepted result; held until the next accepted request.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, TEST, DONE.
REQ-021 IDLE -> TEST SHALL occur when rot_req=1, rot_dir is legal, and cancel=0; on that edge the block SHALL latch cur_orient, rot_dir, is_i_piece, and clear idx to 0.
REQ-022 rot_dir=00, or rot_dir=11 with ENABLE_180=0, SHALL be ignored: the FSM stays in IDLE and done is not pulsed.
REQ-023 rot_req while busy SHALL be ignored and SHALL NOT be queued.
REQ-024 Target orientation: CW is +1 mod 4, CCW is -1 mod 4, 180 is +2 mod 4.
REQ-025 90-degree offsets SHALL come from the GamePkg WK_I_xy / WK_NON_I_xy table entry [idx], chosen by latched is_i_piece and the (from, to) orientation pair.
REQ-026 180-degree offsets SHALL be entry 0 = (0,0) and entry 1 as follows: 0->2 (0,1), 2->0 (0,-1), R->L (1,0), L->R (-1,0).
REQ-027 The 180-degree entry 1 offsets SHALL apply to all pieces.
REQ-028 The test count SHALL be MAX_TESTS for 90-degree rotations and min(2, MAX_TESTS) for 180.
REQ-029 In TEST, test_valid SHALL be 1, with test_dx/test_dy/test_orient registered and stable until test_ack.
REQ-030 test_valid SHALL first rise the cycle after rot_req is accepted.
REQ-031 test_ack may arrive in the same cycle test_valid rises (zero-wait checker) or any number of cycles later.
REQ-032 On test_ack=1 with test_fits=1: go to DONE and load done_ok=1, new_orient=target, kick_dx/kick_dy=current offset, kick_idx=idx.
REQ-033 On test_ack=1 with test_fits=0 and idx < count-1: idx increments, the FSM stays in TEST, and test_valid stays high with the new offset on the next cycle.
REQ-034 On test_ack=1 with test_fits=0 and idx = count-1: go to DONE with done_ok=0; new_orient/kick_dx/kick_dy/kick_idx SHALL keep their prior values.
REQ-035 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-036 Completion latency SHALL be the number of test_ack cycles plus 1 after acceptance.
REQ-037 cancel=1 in TEST SHALL force IDLE on the next edge with no done pulse and results unchanged.
REQ-038 cancel SHALL take priority over a simultaneous test_ack.
REQ-039 cancel in DONE SHALL have no effect; the done pulse still completes.
REQ-040 Offset sign extension to OFFSET_W SHALL be exact for OFFSET_W >= 3.

Reset
REQ-041 On rst_l=0, asynchronously: FSM = IDLE; idx = 0; test_valid, busy, done, done_ok = 0; test_dx, test_dy, kick_dx, kick_dy, kick_idx = 0; test_orient, new_orient = ORIENTATION_0.
REQ-042 Reset asserted mid-TEST SHALL abandon the sequence with no done pulse.

Verification
REQ-043 Non-I, cur_orient=0, CW, test_fits pattern 0,1 -> done_ok=1, new_orient=R, kick=(-1,0), kick_idx=1, done 3 cycles after acceptance with zero-wait ack.
REQ-044 I piece, cur_orient=R, CW, all five fits=0 -> five test_valid offsets (0,0),(-1,0),(2,0),(-1,-2),(2,1), then done=1 with done_ok=0 and results unchanged.
REQ-045 ENABLE_180=1, non-I, cur_orient=2, rot_dir=11, fits pattern 0,1 -> kick=(0,-1), new_orient=0; with ENABLE_180=0 the same request -> busy stays 0.
REQ-046 MAX_TESTS=3, non-I, L->0, all fits=0 -> exactly 3 test_acks consumed, done_ok=0.
REQ-047 cancel during the second test with test_ack=1 and test_fits=1 in the same cycle -> IDLE, no done pulse; then rst_l low mid-TEST -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/wall_kick_sequencer_if.sv
// Candidate-placement handshake between the wall-kick sequencer and a collision checker.
//   master (sequencer): drives test_valid, test_dx, test_dy, test_orient;
//                       receives test_ack, test_fits.
//   slave  (checker)  : the reverse.
// test_fits is meaningful only in a cycle where test_ack is high.
// Orientation encoding: 0 = spawn, 1 = R, 2 = 180, 3 = L.
interface wall_kick_sequencer_if #(
    parameter int unsigned OFFSET_W = 4
);
    logic                       test_valid;
    logic signed [OFFSET_W-1:0] test_dx;
    logic signed [OFFSET_W-1:0] test_dy;
    logic [1:0]                 test_orient;
    logic                       test_ack;
    logic                       test_fits;

    modport master (
        output test_valid, test_dx, test_dy, test_orient,
        input  test_ack, test_fits
    );

    modport slave (
        input  test_valid, test_dx, test_dy, test_orient,
        output test_ack, test_fits
    );
endinterface

// File: rtl/wall_kick_sequencer.sv
// Wall-kick sequencer: walks the SRS kick table for a requested rotation, presenting one
// candidate offset at a time to an external collision checker, and reports the first
// candidate that fits (or failure once the table is exhausted).
// Ports:
//   clk, rst_l           clock, asynchronous active-low reset
//   rot_req, rot_dir     request and direction (01 CW, 10 CCW, 11 180, 00 none)
//   is_i_piece           use the I-tetromino kick table
//   cur_orient           orientation before rotation (0, R=1, 2, L=3)
//   cancel               synchronous abort of a running sequence
//   chk                  candidate handshake (master side)
//   busy, done, done_ok  status and one-cycle completion pulse
//   new_orient, kick_dx, kick_dy, kick_idx   last accepted result
// Offsets use screen coordinates (positive dy points down).
module wall_kick_sequencer #(
    parameter int unsigned MAX_TESTS  = 5,
    parameter bit          ENABLE_180 = 1'b0,
    parameter int unsigned OFFSET_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       rot_req,
    input  logic [1:0]                 rot_dir,
    input  logic                       is_i_piece,
    input  logic [1:0]                 cur_orient,
    input  logic                       cancel,
    wall_kick_sequencer_if.master      chk,
    output logic                       busy,
    output logic                       done,
    output logic                       done_ok,
    output logic [1:0]                 new_orient,
    output logic signed [OFFSET_W-1:0] kick_dx,
    output logic signed [OFFSET_W-1:0] kick_dy,
    output logic [2:0]                 kick_idx
);

    localparam logic [1:0]  ORIENTATION_0 = 2'd0;
    localparam int unsigned CNT_180       = (MAX_TESTS < 2) ? MAX_TESTS : 2;
    localparam logic [2:0]  LAST_90       = 3'(MAX_TESTS - 1);
    localparam logic [2:0]  LAST_180      = 3'(CNT_180 - 1);

    // Rows padded to 8 so a 3-bit index can never fall outside the table.
    localparam int KICK_DX [8][8] = '{
        '{0, -1, -1,  0, -1, 0, 0, 0},  // non-I, into R
        '{0,  1,  1,  0,  1, 0, 0, 0},  // non-I, out of R
        '{0,  1,  1,  0,  1, 0, 0, 0},  // non-I, into L
        '{0, -1, -1,  0, -1, 0, 0, 0},  // non-I, out of L
        '{0, -2,  1, -2,  1, 0, 0, 0},  // I: 0->R, L->2
        '{0,  2, -1,  2, -1, 0, 0, 0},  // I: R->0, 2->L
        '{0, -1,  2, -1,  2, 0, 0, 0},  // I: R->2, 0->L
        '{0,  1, -2,  1, -2, 0, 0, 0}   // I: 2->R, L->0
    };
    localparam int KICK_DY [8][8] = '{
        '{0,  0, -1,  2,  2, 0, 0, 0},
        '{0,  0,  1, -2, -2, 0, 0, 0},
        '{0,  0, -1,  2,  2, 0, 0, 0},
        '{0,  0,  1, -2, -2, 0, 0, 0},
        '{0,  0,  0,  1, -2, 0, 0, 0},
        '{0,  0,  0, -1,  2, 0, 0, 0},
        '{0,  0,  0, -2,  1, 0, 0, 0},
        '{0,  0,  0,  2, -1, 0, 0, 0}
    };

    typedef enum logic [1:0] {StIdle, StTest, StDone} state_e;

    function automatic logic [2:0] kick_row(input logic is_i, input logic [1:0] src,
                                            input logic [1:0] dst);
        logic [2:0] row;
        if (!is_i) begin
            if (dst == 2'd1)      row = 3'd0;
            else if (src == 2'd1) row = 3'd1;
            else if (dst == 2'd3) row = 3'd2;
            else                  row = 3'd3;
        end else begin
            case ({src, dst})
                4'b0001, 4'b1110: row = 3'd4;
                4'b0100, 4'b1011: row = 3'd5;
                4'b0110, 4'b0011: row = 3'd6;
                default:          row = 3'd7;
            endcase
        end
        return row;
    endfunction

    state_e                     state_q, state_d;
    logic [2:0]                 idx_q, idx_d;
    logic [1:0]                 from_q, from_d;
    logic [1:0]                 dir_q, dir_d;
    logic                       is_i_q, is_i_d;
    logic signed [OFFSET_W-1:0] test_dx_q, test_dx_d, test_dy_q, test_dy_d;
    logic [1:0]                 test_orient_q, test_orient_d;
    logic                       done_ok_q, done_ok_d;
    logic [1:0]                 new_orient_q, new_orient_d;
    logic signed [OFFSET_W-1:0] kick_dx_q, kick_dx_d, kick_dy_q, kick_dy_d;
    logic [2:0]                 kick_idx_q, kick_idx_d;

    logic                       dir_legal, accept;
    logic [1:0]                 target;
    logic [2:0]                 idx_inc, last_idx, row;
    logic signed [OFFSET_W-1:0] nxt_dx, nxt_dy;

    assign dir_legal = (rot_dir == 2'b01) || (rot_dir == 2'b10) ||
                       ((rot_dir == 2'b11) && ENABLE_180);
    assign accept    = (state_q == StIdle) && rot_req && dir_legal && !cancel;
    assign idx_inc   = idx_q + 3'd1;
    assign last_idx  = (dir_q == 2'b11) ? LAST_180 : LAST_90;
    assign row       = kick_row(is_i_q, from_q, test_orient_q);

    always_comb begin
        unique case (rot_dir)
            2'b01:   target = cur_orient + 2'd1;
            2'b10:   target = cur_orient - 2'd1;
            default: target = cur_orient + 2'd2;
        endcase
    end

    // Offset for the next table entry; entry 0 is always (0,0) so acceptance never needs it.
    always_comb begin
        nxt_dx = '0;
        nxt_dy = '0;
        if (dir_q == 2'b11) begin
            if (idx_inc == 3'd1) begin
                unique case (from_q)
                    2'd0: nxt_dy = OFFSET_W'(1);
                    2'd1: nxt_dx = OFFSET_W'(1);
                    2'd2: nxt_dy = '1;
                    2'd3: nxt_dx = '1;
                endcase
            end
        end else begin
            nxt_dx = OFFSET_W'(KICK_DX[row][idx_inc]);
            nxt_dy = OFFSET_W'(KICK_DY[row][idx_inc]);
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        from_d        = from_q;
        dir_d         = dir_q;
        is_i_d        = is_i_q;
        test_dx_d     = test_dx_q;
        test_dy_d     = test_dy_q;
        test_orient_d = test_orient_q;
        done_ok_d     = done_ok_q;
        new_orient_d  = new_orient_q;
        kick_dx_d     = kick_dx_q;
        kick_dy_d     = kick_dy_q;
        kick_idx_d    = kick_idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d       = StTest;
                    idx_d         = 3'd0;
                    from_d        = cur_orient;
                    dir_d         = rot_dir;
                    is_i_d        = is_i_piece;
                    test_dx_d     = '0;
                    test_dy_d     = '0;
                    test_orient_d = target;
                end
            end
            StTest: begin
                // cancel wins over a simultaneous ack
                if (cancel) begin
                    state_d = StIdle;
                end else if (chk.test_ack) begin
                    if (chk.test_fits) begin
                        state_d      = StDone;
                        done_ok_d    = 1'b1;
                        new_orient_d = test_orient_q;
                        kick_dx_d    = test_dx_q;
                        kick_dy_d    = test_dy_q;
                        kick_idx_d   = idx_q;
                    end else if (idx_q == last_idx) begin
                        state_d   = StDone;
                        done_ok_d = 1'b0;
                    end else begin
                        idx_d     = idx_inc;
                        test_dx_d = nxt_dx;
                        test_dy_d = nxt_dy;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= StIdle;
            idx_q         <= 3'd0;
            from_q        <= ORIENTATION_0;
            dir_q         <= 2'b00;
            is_i_q        <= 1'b0;
            test_dx_q     <= '0;
            test_dy_q     <= '0;
            test_orient_q <= ORIENTATION_0;
            done_ok_q     <= 1'b0;
            new_orient_q  <= ORIENTATION_0;
            kick_dx_q     <= '0;
            kick_dy_q     <= '0;
            kick_idx_q    <= 3'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            from_q        <= from_d;
            dir_q         <= dir_d;
            is_i_q        <= is_i_d;
            test_dx_q     <= test_dx_d;
            test_dy_q     <= test_dy_d;
            test_orient_q <= test_orient_d;
            done_ok_q     <= done_ok_d;
            new_orient_q  <= new_orient_d;
            kick_dx_q     <= kick_dx_d;
            kick_dy_q     <= kick_dy_d;
            kick_idx_q    <= kick_idx_d;
        end
    end

    assign chk.test_valid  = (state_q == StTest);
    assign chk.test_dx     = test_dx_q;
    assign chk.test_dy     = test_dy_q;
    assign chk.test_orient = test_orient_q;
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign done_ok         = done_ok_q;
    assign new_orient      = new_orient_q;
    assign kick_dx         = kick_dx_q;
    assign kick_dy         = kick_dy_q;
    assign kick_idx        = kick_idx_q;

endmodule

// File: tb/tb_wall_kick_sequencer.sv
// Bench for wall_kick_sequencer. Three instances: defaults (5 tests, no 180),
// 180 enabled with 5 tests, and 180 enabled with 3 tests.
// The reference model derives kicks from the SRS per-orientation offset data
// (kick = offset[from] - offset[to], rebased on entry 0), flipped to y-down.
module tb_wall_kick_sequencer;
    localparam int NU = 3;

    // SRS offset data, y-up, indexed [orientation][test]
    localparam int JX [4][5] = '{'{0,0,0,0,0}, '{0,1,1,0,1}, '{0,0,0,0,0}, '{0,-1,-1,0,-1}};
    localparam int JY [4][5] = '{'{0,0,0,0,0}, '{0,0,-1,2,2}, '{0,0,0,0,0}, '{0,0,-1,2,2}};
    localparam int IX [4][5] = '{'{0,-1,2,-1,2}, '{-1,0,0,0,0}, '{-1,1,-2,1,-2}, '{0,0,0,0,0}};
    localparam int IY [4][5] = '{'{0,0,0,0,0}, '{0,0,0,1,-2}, '{1,1,1,0,0}, '{1,1,1,-1,2}};

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    logic [NU-1:0] rot_req_v, is_i_v, cancel_v, ack_v, fits_v;
    logic [1:0]    rot_dir_a [NU];
    logic [1:0]    cur_or_a  [NU];
    logic [NU-1:0] busy_v, done_v, ok_v, tv_v;
    logic [1:0]    nor_a [NU];
    logic [1:0]    tor_a [NU];
    logic signed [3:0] kdx_a [NU];
    logic signed [3:0] kdy_a [NU];
    logic signed [3:0] tdx_a [NU];
    logic signed [3:0] tdy_a [NU];
    logic [2:0]    kidx_a [NU];

    int total = 0;
    int bad   = 0;
    int max_t [NU] = '{5, 5, 3};
    bit en180 [NU] = '{1'b0, 1'b1, 1'b1};

    // Expected held results per instance
    logic [1:0] e_nor  [NU];
    int         e_kdx  [NU];
    int         e_kdy  [NU];
    int         e_kidx [NU];

    for (genvar g = 0; g < NU; g++) begin : g_u
        wall_kick_sequencer_if #(.OFFSET_W(4)) ifc ();
        wall_kick_sequencer #(
            .MAX_TESTS ((g == 2) ? 3 : 5),
            .ENABLE_180(g != 0),
            .OFFSET_W  (4)
        ) dut (
            .clk       (clk),
            .rst_l     (rst_l),
            .rot_req   (rot_req_v[g]),
            .rot_dir   (rot_dir_a[g]),
            .is_i_piece(is_i_v[g]),
            .cur_orient(cur_or_a[g]),
            .cancel    (cancel_v[g]),
            .chk       (ifc),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .done_ok   (ok_v[g]),
            .new_orient(nor_a[g]),
            .kick_dx   (kdx_a[g]),
            .kick_dy   (kdy_a[g]),
            .kick_idx  (kidx_a[g])
        );
        assign ifc.test_ack  = ack_v[g];
        assign ifc.test_fits = fits_v[g];
        assign tv_v[g]       = ifc.test_valid;
        assign tdx_a[g]      = ifc.test_dx;
        assign tdy_a[g]      = ifc.test_dy;
        assign tor_a[g]      = ifc.test_orient;
    end

    function automatic void ref_off(input bit is_i, input int from, input int dst, input int k,
                                    output int dx, output int dy);
        dx = 0;
        dy = 0;
        if ((dst - from + 4) % 4 == 2) begin
            if (k == 1) begin
                if (from == 0)      dy = 1;
                else if (from == 2) dy = -1;
                else if (from == 1) dx = 1;
                else                dx = -1;
            end
        end else if (is_i) begin
            dx = (IX[from][k] - IX[dst][k]) - (IX[from][0] - IX[dst][0]);
            dy = -((IY[from][k] - IY[dst][k]) - (IY[from][0] - IY[dst][0]));
        end else begin
            dx = JX[from][k] - JX[dst][k];
            dy = -(JY[from][k] - JY[dst][k]);
        end
    endfunction

    task automatic clear_expect();
        for (int u = 0; u < NU; u++) begin
            e_nor[u] = 2'd0; e_kdx[u] = 0; e_kdy[u] = 0; e_kidx[u] = 0;
        end
    endtask

    // One rotation on instance u. fits_mask bit k = checker answer for test k.
    task automatic run_rot(input int u, input int from, input int dir, input bit is_i,
                           input int fits_mask, input int max_wait, input int cancel_at,
                           input bit poke, input bit cancel_done, input string tag);
        int dst, cnt, dx, dy, w;
        bit legal;
        legal = (dir == 1) || (dir == 2) || (dir == 3 && en180[u]);
        dst   = (from + ((dir == 1) ? 1 : (dir == 2) ? 3 : 2)) % 4;
        cnt   = (dir == 3) ? ((max_t[u] < 2) ? max_t[u] : 2) : max_t[u];
        @(negedge clk);
        rot_req_v[u] = 1'b1; rot_dir_a[u] = 2'(dir); cur_or_a[u] = 2'(from); is_i_v[u] = is_i;
        @(negedge clk);
        // scramble request inputs to prove they were latched
        rot_req_v[u] = 1'b0; rot_dir_a[u] = 2'($urandom); cur_or_a[u] = 2'($urandom);
        is_i_v[u] = 1'($urandom);
        if (!legal) begin
            repeat (2) begin
                total++;
                if (busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 || tv_v[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s ignore: busy=%b done=%b valid=%b want 0 0 0",
                             tag, busy_v[u], done_v[u], tv_v[u]);
                end
                @(negedge clk);
            end
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            ref_off(is_i, from, dst, k, dx, dy);
            w = int'($urandom_range(max_wait, 0));
            for (int j = 0; j <= w; j++) begin
                total++;
                if (tv_v[u] !== 1'b1 || busy_v[u] !== 1'b1 || done_v[u] !== 1'b0 ||
                    tor_a[u] !== 2'(dst) || tdx_a[u] !== 4'(dx) || tdy_a[u] !== 4'(dy)) begin
                    bad++;
                    $display("FAIL %s cand k=%0d: valid=%b busy=%b done=%b or=%0d dx=%0d dy=%0d want 1 1 0 or=%0d dx=%0d dy=%0d",
                             tag, k, tv_v[u], busy_v[u], done_v[u], tor_a[u], tdx_a[u],
                             tdy_a[u], dst, dx, dy);
                end
                if (poke && j == 0) rot_req_v[u] = 1'b1;
                if (j == w) begin
                    ack_v[u] = 1'b1; fits_v[u] = fits_mask[k]; cancel_v[u] = (k == cancel_at);
                end else begin
                    ack_v[u] = 1'b0; fits_v[u] = 1'($urandom);
                end
                @(negedge clk);
            end
            ack_v[u] = 1'b0; cancel_v[u] = 1'b0; rot_req_v[u] = 1'b0;
            if (k == cancel_at) begin
                total++;
                if (busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 ||
                    {nor_a[u], kdx_a[u], kdy_a[u], kidx_a[u]} !==
                    {e_nor[u], 4'(e_kdx[u]), 4'(e_kdy[u]), 3'(e_kidx[u])}) begin
                    bad++;
                    $display("FAIL %s cancel: busy=%b done=%b res=%0d,%0d,%0d,%0d want 0 0 res=%0d,%0d,%0d,%0d",
                             tag, busy_v[u], done_v[u], nor_a[u], kdx_a[u], kdy_a[u], kidx_a[u],
                             e_nor[u], e_kdx[u], e_kdy[u], e_kidx[u]);
                end
                return;
            end
            if (fits_mask[k] || k == cnt - 1) begin
                if (fits_mask[k]) begin
                    e_nor[u] = 2'(dst); e_kdx[u] = dx; e_kdy[u] = dy; e_kidx[u] = k;
                end
                total++;
                if (done_v[u] !== 1'b1 || busy_v[u] !== 1'b1 || tv_v[u] !== 1'b0 ||
                    ok_v[u] !== 1'(fits_mask[k]) ||
                    {nor_a[u], kdx_a[u], kdy_a[u], kidx_a[u]} !==
                    {e_nor[u], 4'(e_kdx[u]), 4'(e_kdy[u]), 3'(e_kidx[u])}) begin
                    bad++;
                    $display("FAIL %s done: done=%b busy=%b valid=%b ok=%b res=%0d,%0d,%0d,%0d want 1 1 0 ok=%b res=%0d,%0d,%0d,%0d",
                             tag, done_v[u], busy_v[u], tv_v[u], ok_v[u], nor_a[u], kdx_a[u],
                             kdy_a[u], kidx_a[u], fits_mask[k], e_nor[u], e_kdx[u], e_kdy[u],
                             e_kidx[u]);
                end
                if (cancel_done) cancel_v[u] = 1'b1;
                @(negedge clk);
                cancel_v[u] = 1'b0;
                total++;
                if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b0 || tv_v[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle: done=%b busy=%b valid=%b want 0 0 0",
                             tag, done_v[u], busy_v[u], tv_v[u]);
                end
                if (poke) begin
                    @(negedge clk);
                    total++;
                    if (busy_v[u] !== 1'b0) begin
                        bad++;
                        $display("FAIL %s no_queue: busy=%b want 0", tag, busy_v[u]);
                    end
                end
                return;
            end
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < NU; u++) begin
            total++;
            if ({busy_v[u], done_v[u], ok_v[u], tv_v[u], nor_a[u], tor_a[u], kdx_a[u],
                 kdy_a[u], tdx_a[u], tdy_a[u], kidx_a[u]} !== 27'd0) begin
                bad++;
                $display("FAIL reset u=%0d: busy=%b done=%b ok=%b valid=%b nor=%0d tor=%0d kdx=%0d kdy=%0d tdx=%0d tdy=%0d kidx=%0d want all 0",
                         u, busy_v[u], done_v[u], ok_v[u], tv_v[u], nor_a[u], tor_a[u],
                         kdx_a[u], kdy_a[u], tdx_a[u], tdy_a[u], kidx_a[u]);
            end
        end
    endtask

    task automatic test_cw_kick();
        run_rot(0, 0, 1, 1'b0, 'b10, 0, -1, 1'b0, 1'b0, "cw_kick");
        total++;
        if ({nor_a[0], kdx_a[0], kdy_a[0], kidx_a[0], ok_v[0]} !==
            {2'd1, 4'hF, 4'd0, 3'd1, 1'b1}) begin
            bad++;
            $display("FAIL cw_kick_lit: res=%0d,%0d,%0d,%0d ok=%b want 1,-1,0,1 ok=1",
                     nor_a[0], kdx_a[0], kdy_a[0], kidx_a[0], ok_v[0]);
        end
    endtask

    task automatic test_i_all_fail();
        int dxl [5];
        int dyl [5];
        dxl = '{0, -1, 2, -1, 2};
        dyl = '{0, 0, 0, -2, 1};
        @(negedge clk);
        rot_req_v[0] = 1'b1; rot_dir_a[0] = 2'b01; cur_or_a[0] = 2'd1; is_i_v[0] = 1'b1;
        @(negedge clk);
        rot_req_v[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (tv_v[0] !== 1'b1 || tdx_a[0] !== 4'(dxl[k]) || tdy_a[0] !== 4'(dyl[k]) ||
                tor_a[0] !== 2'd2) begin
                bad++;
                $display("FAIL i_fail cand k=%0d: valid=%b dx=%0d dy=%0d or=%0d want 1 %0d %0d 2",
                         k, tv_v[0], tdx_a[0], tdy_a[0], tor_a[0], dxl[k], dyl[k]);
            end
            ack_v[0] = 1'b1; fits_v[0] = 1'b0;
            @(negedge clk);
            ack_v[0] = 1'b0;
        end
        total++;
        if (done_v[0] !== 1'b1 || ok_v[0] !== 1'b0 ||
            {nor_a[0], kdx_a[0], kdy_a[0], kidx_a[0]} !== {2'd1, 4'hF, 4'd0, 3'd1}) begin
            bad++;
            $display("FAIL i_fail done: done=%b ok=%b res=%0d,%0d,%0d,%0d want 1 0 res=1,-1,0,1",
                     done_v[0], ok_v[0], nor_a[0], kdx_a[0], kdy_a[0], kidx_a[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_180();
        run_rot(1, 2, 3, 1'b0, 'b10, 1, -1, 1'b0, 1'b0, "rot180");
        total++;
        if ({nor_a[1], kdx_a[1], kdy_a[1]} !== {2'd0, 4'd0, 4'hF}) begin
            bad++;
            $display("FAIL rot180_lit: res=%0d,%0d,%0d want 0,0,-1", nor_a[1], kdx_a[1], kdy_a[1]);
        end
        run_rot(0, 2, 3, 1'b0, 'b10, 0, -1, 1'b0, 1'b0, "rot180_off");
    endtask

    task automatic test_cancel_and_reset();
        run_rot(0, 1, 2, 1'b1, 'b10, 0, 1, 1'b0, 1'b0, "cancel_ack");
        run_rot(1, 3, 1, 1'b0, 'b00100, 1, -1, 1'b0, 1'b1, "cancel_in_done");
        @(negedge clk);
        rot_req_v[1] = 1'b1; rot_dir_a[1] = 2'b10; cur_or_a[1] = 2'd0; is_i_v[1] = 1'b1;
        @(negedge clk);
        rot_req_v[1] = 1'b0;
        @(negedge clk);
        #1 rst_l = 1'b0;
        #1;
        clear_expect();
        test_reset();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int u, ca;
            u  = int'($urandom_range(NU - 1, 0));
            ca = ($urandom_range(5, 0) == 0) ? int'($urandom_range(4, 0)) : -1;
            run_rot(u, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom),
                    int'($urandom_range(31, 0)) & int'($urandom_range(31, 0)), 2, ca,
                    1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        rst_l = 1'b0;
        rot_req_v = '0; is_i_v = '0; cancel_v = '0; ack_v = '0; fits_v = '0;
        for (int u = 0; u < NU; u++) begin
            rot_dir_a[u] = 2'b00; cur_or_a[u] = 2'd0;
        end
        clear_expect();
        #12;
        test_reset();
        @(negedge clk);
        rst_l = 1'b1;
        test_cw_kick();
        test_i_all_fail();
        test_180();
        run_rot(2, 3, 1, 1'b0, 0, 2, -1, 1'b0, 1'b0, "max3");
        run_rot(2, 0, 0, 1'b1, 'b1, 0, -1, 1'b0, 1'b0, "dir_none");
        run_rot(0, 2, 2, 1'b1, 'b1000, 0, -1, 1'b1, 1'b0, "busy_poke");
        test_cancel_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
